// File: rtl/ucode_pkg.sv
// ============================================================================
// Module : ucode_pkg
// Brief  : Shared types for the microcoded control store (micro-addresses,
//          next-address codes, opcodes, microword layout, FSM states).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ucode_pkg;

    localparam logic [3:0] UA_FETCH    = 4'd0;
    localparam logic [3:0] UA_DECODE   = 4'd1;
    localparam logic [3:0] UA_MEMADR   = 4'd2;
    localparam logic [3:0] UA_MEMREAD  = 4'd3;
    localparam logic [3:0] UA_MEMWB    = 4'd4;
    localparam logic [3:0] UA_MEMWRITE = 4'd5;
    localparam logic [3:0] UA_EXECR    = 4'd6;
    localparam logic [3:0] UA_ALUWB    = 4'd7;
    localparam logic [3:0] UA_EXECI    = 4'd8;
    localparam logic [3:0] UA_JAL      = 4'd9;
    localparam logic [3:0] UA_BEQ      = 4'd10;

    typedef enum logic [2:0] {
        AC_SEQ   = 3'b000,
        AC_DISP1 = 3'b001,
        AC_DISP2 = 3'b010,
        AC_FETCH = 3'b011,
        AC_ALUWB = 3'b100
    } addr_ctl_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;

    typedef struct packed {
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       mem;
        addr_ctl_e  addr_ctl;
    } microword_t;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    function automatic logic disp1_legal(input logic [6:0] i_op);
        case (i_op)
            OP_R, OP_I, OP_JAL, OP_BEQ, OP_LW, OP_SW: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic disp2_legal(input logic [6:0] i_op);
        case (i_op)
            OP_LW, OP_SW: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ucode_rom.sv
// ============================================================================
// Module : ucode_rom
// Brief  : Combinational microcode ROM, micro-address to microword plus valid.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ucode_rom
    import ucode_pkg::*;
(
    input  logic [3:0] i_uaddr,
    output microword_t o_word,
    output logic       o_valid
);

    always_comb begin
        o_word  = '0;
        o_valid = 1'b1;
        case (i_uaddr)
            UA_FETCH: begin
                o_word.ir_write   = 1'b1;
                o_word.pc_update  = 1'b1;
                o_word.alu_src_b  = 2'b10;
                o_word.result_src = 2'b10;
                o_word.mem        = 1'b1;
                o_word.addr_ctl   = AC_SEQ;
            end
            UA_DECODE: begin
                o_word.alu_src_a  = 2'b01;
                o_word.alu_src_b  = 2'b01;
                o_word.addr_ctl   = AC_DISP1;
            end
            UA_MEMADR: begin
                o_word.alu_src_a  = 2'b10;
                o_word.alu_src_b  = 2'b01;
                o_word.addr_ctl   = AC_DISP2;
            end
            UA_MEMREAD: begin
                o_word.adr_src    = 1'b1;
                o_word.mem        = 1'b1;
                o_word.addr_ctl   = AC_SEQ;
            end
            UA_MEMWB: begin
                o_word.result_src = 2'b01;
                o_word.reg_write  = 1'b1;
                o_word.addr_ctl   = AC_FETCH;
            end
            UA_MEMWRITE: begin
                o_word.adr_src    = 1'b1;
                o_word.mem_write  = 1'b1;
                o_word.mem        = 1'b1;
                o_word.addr_ctl   = AC_FETCH;
            end
            UA_EXECR: begin
                o_word.alu_src_a  = 2'b10;
                o_word.alu_op     = 2'b10;
                o_word.addr_ctl   = AC_SEQ;
            end
            UA_ALUWB: begin
                o_word.reg_write  = 1'b1;
                o_word.addr_ctl   = AC_FETCH;
            end
            UA_EXECI: begin
                o_word.alu_src_a  = 2'b10;
                o_word.alu_src_b  = 2'b01;
                o_word.alu_op     = 2'b10;
                o_word.addr_ctl   = AC_ALUWB;
            end
            UA_JAL: begin
                o_word.alu_src_a  = 2'b01;
                o_word.alu_src_b  = 2'b10;
                o_word.pc_update  = 1'b1;
                o_word.addr_ctl   = AC_ALUWB;
            end
            UA_BEQ: begin
                o_word.alu_src_a  = 2'b10;
                o_word.alu_op     = 2'b01;
                o_word.branch     = 1'b1;
                o_word.addr_ctl   = AC_FETCH;
            end
            default: o_valid = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ucode_control_store.sv
// ============================================================================
// Module : ucode_control_store
// Brief  : Control store / decode stage with memory wait handshake, wait
//          timeout and sticky fault. Optional perf counters: UCODE_PERF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ucode_control_store
    import ucode_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  uaddr,
    input  logic [6:0]  op,
    input  logic        mem_ready,
    output logic [2:0]  addr_ctl,
    output logic        seq_en,
    output logic        mem_req,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_update,
    output logic        branch,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
`ifdef UCODE_PERF_EN
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_instret,
`endif
    output logic        fault
);

    localparam int unsigned c_cnt_w = (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_last =
        (WAIT_LIMIT == 0) ? '0 : c_cnt_w'(WAIT_LIMIT - 1);

    state_e             r_state;
    state_e             w_next;
    logic [c_cnt_w-1:0] r_wait_cnt;
    microword_t         w_word;
    logic               w_valid;
    logic               w_illegal;
    logic               w_stall;
    logic               w_go;
    logic               w_timeout;

    ucode_rom u_rom (
        .i_uaddr (uaddr),
        .o_word  (w_word),
        .o_valid (w_valid)
    );

    assign w_illegal = !w_valid
                    || (uaddr == UA_DECODE && !disp1_legal(op))
                    || (uaddr == UA_MEMADR && !disp2_legal(op));
    assign w_stall   = (r_state == ST_RUN) && !w_illegal && w_word.mem && !mem_ready;
    assign w_go      = !w_word.mem || mem_ready;
    // Fault on the edge that would record the WAIT_LIMIT-th non-ready cycle.
    assign w_timeout = (WAIT_LIMIT != 0) && w_stall && (r_wait_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_stall ? r_wait_cnt + c_cnt_w'(1) : '0;
        end
    end

    always_comb begin
        w_next     = r_state;
        addr_ctl   = AC_FETCH;
        seq_en     = 1'b0;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        fault      = 1'b0;
        case (r_state)
            ST_BOOT: begin
                seq_en = 1'b1;
                w_next = ST_RUN;
            end
            ST_RUN: begin
                addr_ctl   = w_word.addr_ctl;
                alu_src_a  = w_word.alu_src_a;
                alu_src_b  = w_word.alu_src_b;
                alu_op     = w_word.alu_op;
                result_src = w_word.result_src;
                if (w_illegal) begin
                    w_next = ST_FAULT;
                end else begin
                    // Strobes only fire on the cycle the access completes.
                    seq_en    = w_go;
                    mem_req   = w_word.mem;
                    adr_src   = w_word.adr_src;
                    ir_write  = w_word.ir_write  & w_go;
                    pc_update = w_word.pc_update & w_go;
                    branch    = w_word.branch    & w_go;
                    mem_write = w_word.mem_write & w_go;
                    reg_write = w_word.reg_write & w_go;
                    if (w_timeout) begin
                        w_next = ST_FAULT;
                    end
                end
            end
            ST_FAULT: fault = 1'b1;
            default: begin
                fault  = 1'b1;
                w_next = ST_FAULT;
            end
        endcase
    end

`ifdef UCODE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles  <= '0;
            perf_instret <= '0;
        end else if (r_state == ST_RUN) begin
            perf_cycles <= perf_cycles + 32'd1;
            if (seq_en && addr_ctl == AC_FETCH) begin
                perf_instret <= perf_instret + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ucode_control_store.sv
// ============================================================================
// Module : tb_ucode_control_store
// Brief  : Scoreboard bench for ucode_control_store (WAIT_LIMIT = 4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ucode_control_store;

    logic        clk;
    logic        rst_n;
    logic [3:0]  uaddr;
    logic [6:0]  op;
    logic        mem_ready;
    logic [2:0]  addr_ctl;
    logic        seq_en, mem_req, adr_src, ir_write, pc_update, branch;
    logic        mem_write, reg_write, fault;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
`ifdef UCODE_PERF_EN
    logic [31:0] perf_cycles, perf_instret;
`endif

    ucode_control_store #(.WAIT_LIMIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uaddr      (uaddr),
        .op         (op),
        .mem_ready  (mem_ready),
        .addr_ctl   (addr_ctl),
        .seq_en     (seq_en),
        .mem_req    (mem_req),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_update  (pc_update),
        .branch     (branch),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
`ifdef UCODE_PERF_EN
        .perf_cycles  (perf_cycles),
        .perf_instret (perf_instret),
`endif
        .fault      (fault)
    );

    typedef struct {
        string       name;
        logic [19:0] vec;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RR  = 7'b0110011;
    localparam logic [6:0] BAD = 7'b1110011;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Field order: addr_ctl, seq_en, mem_req, adr_src, ir_write, pc_update,
    // branch, mem_write, reg_write, alu_src_a, alu_src_b, alu_op, result_src, fault
    function automatic logic [19:0] mk(input logic [2:0] ac, input logic seq, input logic mreq,
                                       input logic adr, input logic irw, input logic pcu,
                                       input logic br, input logic mw, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] aop, input logic [1:0] rs,
                                       input logic flt);
        return {ac, seq, mreq, adr, irw, pcu, br, mw, rw, a, b, aop, rs, flt};
    endfunction

    logic [19:0] w_act;
    assign w_act = {addr_ctl, seq_en, mem_req, adr_src, ir_write, pc_update, branch,
                    mem_write, reg_write, alu_src_a, alu_src_b, alu_op, result_src, fault};

    // Monitor: one scoreboard entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            if (w_act !== e.vec) begin
                n_errors++;
                $display("FAIL %s: got %b expected %b", e.name, w_act, e.vec);
            end
        end
    end

    task automatic step(input string nm, input logic [3:0] ua, input logic [6:0] o,
                        input logic mr, input logic [19:0] exp_vec);
        exp_t e;
        uaddr     = ua;
        op        = o;
        mem_ready = mr;
        e.name    = nm;
        e.vec     = exp_vec;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    logic [19:0] BOOT, FLT, FETCH, DECODE, MRD_WAIT, MRD;

    task automatic reboot(input string nm);
        rst_n = 1'b0;
        step({nm, "_rst"}, 4'd0, LW, 1'b0, BOOT);
        rst_n = 1'b1;
        step({nm, "_boot"}, 4'd0, LW, 1'b1, BOOT);
    endtask

    initial begin
        BOOT     = mk(3'b011, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        FLT      = mk(3'b011, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        FETCH    = mk(3'b000, 1, 1, 0, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0);
        DECODE   = mk(3'b001, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
        MRD_WAIT = mk(3'b000, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        MRD      = mk(3'b000, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);

        rst_n = 1'b0; uaddr = 4'd0; op = 7'd0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step("rst_hold", 4'd0, LW, 1'b0, BOOT);
        rst_n = 1'b1;
        step("boot", 4'd0, LW, 1'b1, BOOT);

        // lw flow
        step("fetch",   4'd0, LW, 1'b1, FETCH);
        step("decode",  4'd1, LW, 1'b1, DECODE);
        step("memadr",  4'd2, LW, 1'b1, mk(3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0));
        step("memread", 4'd3, LW, 1'b1, MRD);
        step("memwb",   4'd4, LW, 1'b1, mk(3'b011, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 0));

        // fetch stall then completion
        step("fetch_wait", 4'd0, LW, 1'b0, mk(3'b000, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0));
        step("fetch_go",   4'd0, LW, 1'b1, FETCH);

        // store wait handshake: three non-ready cycles then ready
        for (int i = 0; i < 3; i++)
            step("sw_wait", 4'd5, SW, 1'b0, mk(3'b011, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        step("sw_done", 4'd5, SW, 1'b1, mk(3'b011, 1, 1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));

        // remaining microstates
        step("execr",    4'd6,  RR, 1'b0, mk(3'b000, 1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0));
        step("aluwb",    4'd7,  RR, 1'b0, mk(3'b011, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        step("execi",    4'd8,  RR, 1'b0, mk(3'b100, 1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 0));
        step("jal",      4'd9,  RR, 1'b0, mk(3'b100, 1, 0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0));
        step("beq",      4'd10, RR, 1'b0, mk(3'b011, 1, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 0));
        step("decode_r", 4'd1,  RR, 1'b1, DECODE);

        // timeout: fault after the fourth non-ready edge, sticky afterwards
        for (int i = 0; i < 4; i++)
            step("to_wait", 4'd3, LW, 1'b0, MRD_WAIT);
        step("to_fault", 4'd3, LW, 1'b0, FLT);
        step("to_hold",  4'd3, LW, 1'b1, FLT);

        // asynchronous reset from FAULT, asserted between edges
        rst_n = 1'b0;
        #1;
`ifdef UCODE_PERF_EN
        n_checks++;
        if (perf_cycles !== 32'd0 || perf_instret !== 32'd0) begin
            n_errors++;
            $display("FAIL perf_rst: got %0d/%0d expected 0/0", perf_cycles, perf_instret);
        end
`endif
        step("arst_fault", 4'd3, LW, 1'b0, BOOT);
        rst_n = 1'b1;
        step("arst_boot", 4'd0, LW, 1'b1, BOOT);

        // illegal opcode at dispatch1
        step("ill_op",     4'd1, BAD, 1'b1, mk(3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0));
        step("ill_op_flt", 4'd0, LW,  1'b1, FLT);
        reboot("r1");

        // illegal micro-address
        step("ill_addr",     4'd12, LW, 1'b1, mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        step("ill_addr_flt", 4'd0,  LW, 1'b1, FLT);
        reboot("r2");

        // non load/store opcode at dispatch2
        step("ill_d2",     4'd2, RR, 1'b1, mk(3'b010, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0));
        step("ill_d2_flt", 4'd0, LW, 1'b1, FLT);
        reboot("r3");

        // reset mid-wait, then a fresh three-cycle wait must not time out
        step("mw_wait", 4'd3, LW, 1'b0, MRD_WAIT);
        step("mw_wait", 4'd3, LW, 1'b0, MRD_WAIT);
        rst_n = 1'b0;
        step("arst_wait", 4'd3, LW, 1'b0, BOOT);
        rst_n = 1'b1;
        step("arst_wait_boot", 4'd3, LW, 1'b0, BOOT);
        for (int i = 0; i < 3; i++)
            step("post_wait", 4'd3, LW, 1'b0, MRD_WAIT);
        step("post_done", 4'd3, LW, 1'b1, MRD);

        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(negedge clk);
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
